accum_banked_memory: RTL and testbench

ACCUM_BANKED_MEMORY -- requirements
Module: accum_banked_memory

---
 rtl/accum_banked_memory.sv | 112 +++++++++++
 tb/tb_accum_banked_memory.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/accum_banked_memory.sv
// accum_banked_memory: banked RAM with overwrite/accumulate writes, read-first reads and bulk clear
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   ready               requests accepted this cycle (FSM in IDLE)
//   wr_en, wr_acc       write request; 1 = accumulate into entry, 0 = overwrite
//   waddr_in, wdata_in  write address (low bits pick the bank) and signed data
//   rd_en, raddr_in     read request and address
//   rdata_out, rvalid   read data (held between reads) and one-cycle valid pulse
//   clr_start, clr_done start zeroing every entry; pulse when clearing finishes
//   ovf_flag            sticky signed overflow of any accumulate
module accum_banked_memory #(
   parameter  int RAM_WIDTH      = 32,
   parameter  int NUM_BANKS      = 4,
   parameter  int BANK_ADDR_BITS = 8,
   localparam int BS             = $clog2(NUM_BANKS),
   localparam int ADDR_BITS      = BS + BANK_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rstn,
   output logic                 ready,
   input  logic                 wr_en,
   input  logic                 wr_acc,
   input  logic [ADDR_BITS-1:0] waddr_in,
   input  logic [RAM_WIDTH-1:0] wdata_in,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] raddr_in,
   output logic [RAM_WIDTH-1:0] rdata_out,
   output logic                 rvalid,
   input  logic                 clr_start,
   output logic                 clr_done,
   output logic                 ovf_flag
);
   localparam int BW   = BS > 0 ? BS : 1;
   localparam int OFFS = 2 ** BANK_ADDR_BITS;
   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
   state_t                    state;
   logic [BANK_ADDR_BITS-1:0] cnt;
   logic                      s1_v, s1_acc;
   logic [ADDR_BITS-1:0]      s1_addr;
   logic [RAM_WIDTH-1:0]      s1_data;
   logic [RAM_WIDTH-1:0]      mem [NUM_BANKS][OFFS];
   logic [RAM_WIDTH-1:0]      old, sum, wval;
   logic                      ovf_now, acc_clr, acc_wr, acc_rd;

   function automatic logic [BW-1:0] bank_of(input logic [ADDR_BITS-1:0] a);
      return BW'(a % ADDR_BITS'(NUM_BANKS));
   endfunction

   function automatic logic [BANK_ADDR_BITS-1:0] off_of(input logic [ADDR_BITS-1:0] a);
      return BANK_ADDR_BITS'(a >> BS);
   endfunction

   // The S1 commit reads the array combinationally at its own commit edge, so the
   // previous write (committed one edge earlier) is already visible: back-to-back
   // accumulates chain without a separate bypass.
   always_comb begin
      ready   = state == IDLE;
      acc_clr = ready & clr_start;
      acc_wr  = ready & wr_en & ~clr_start;
      acc_rd  = ready & rd_en & ~clr_start;
      old     = mem[bank_of(s1_addr)][off_of(s1_addr)];
      sum     = old + s1_data;
      wval    = s1_acc ? sum : s1_data;
      ovf_now = s1_v & s1_acc & (old[RAM_WIDTH-1] == s1_data[RAM_WIDTH-1]) & (sum[RAM_WIDTH-1] != old[RAM_WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         s1_v      <= 1'b0;
         s1_acc    <= 1'b0;
         s1_addr   <= '0;
         s1_data   <= '0;
         rvalid    <= 1'b0;
         rdata_out <= '0;
         clr_done  <= 1'b0;
         ovf_flag  <= 1'b0;
      end else begin
         s1_v     <= acc_wr;
         s1_acc   <= wr_acc;
         s1_addr  <= waddr_in;
         s1_data  <= wdata_in;
         rvalid   <= acc_rd;
         clr_done <= 1'b0;
         ovf_flag <= acc_clr ? 1'b0 : ovf_flag | ovf_now;
         if (acc_rd) rdata_out <= mem[bank_of(raddr_in)][off_of(raddr_in)];
         case (state)
            IDLE:  state <= acc_clr ? DRAIN : IDLE;
            DRAIN: begin
               state <= CLEAR;
               cnt   <= '0;
            end
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (&cnt) begin
                  state    <= IDLE;
                  clr_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array contents are deliberately not reset; clear zeroes one offset in every bank per cycle.
   always_ff @(posedge clk) begin
      if (s1_v) mem[bank_of(s1_addr)][off_of(s1_addr)] <= wval;
      if (state == CLEAR)
         for (int b = 0; b < NUM_BANKS; b++) mem[BW'(b)][cnt] <= '0;
   end
endmodule

// File: tb/tb_accum_banked_memory.sv
// tb_accum_banked_memory: directed self-checking bench for accum_banked_memory
module tb_accum_banked_memory;
   localparam int RW = 32;
   localparam int AB = 10;
   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ready, wr_en = 1'b0, wr_acc = 1'b0, rd_en = 1'b0, clr_start = 1'b0;
   logic [AB-1:0] waddr_in = '0, raddr_in = '0;
   logic [RW-1:0] wdata_in = '0, rdata_out;
   logic          rvalid, clr_done, ovf_flag;
   int            checks = 0, errors = 0;

   accum_banked_memory #(.RAM_WIDTH(32), .NUM_BANKS(4), .BANK_ADDR_BITS(8)) dut (
      .clk(clk), .rstn(rstn), .ready(ready), .wr_en(wr_en), .wr_acc(wr_acc),
      .waddr_in(waddr_in), .wdata_in(wdata_in), .rd_en(rd_en), .raddr_in(raddr_in),
      .rdata_out(rdata_out), .rvalid(rvalid), .clr_start(clr_start), .clr_done(clr_done),
      .ovf_flag(ovf_flag)
   );

   always #5 clk = ~clk;

   task cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task wr(input logic acc, input logic [AB-1:0] a, input logic [RW-1:0] d);
      wr_en = 1'b1; wr_acc = acc; waddr_in = a; wdata_in = d;
      @(negedge clk);
      wr_en = 1'b0; wr_acc = 1'b0;
   endtask

   task rd(input logic [AB-1:0] a, output logic [RW-1:0] d, output logic v);
      rd_en = 1'b1; raddr_in = a;
      @(negedge clk);
      d = rdata_out; v = rvalid;
      rd_en = 1'b0;
   endtask

   task test_reset();
      #12;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done: got %b want 0", clr_done); end
      checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_flag); end
      checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_out); end
      @(negedge clk); rstn = 1'b1;
      cyc();
   endtask

   task test_overwrite();
      logic [RW-1:0] d; logic v;
      wr(1'b0, 10'd5, 32'h12);
      cyc();
      rd(10'd5, d, v);
      checks++; if (d !== 32'h12 || v !== 1'b1) begin errors++; $display("FAIL overwrite_read: got %h/%b want 00000012/1", d, v); end
      cyc();
      checks++; if (rvalid !== 1'b0 || rdata_out !== 32'h12) begin errors++; $display("FAIL rvalid_pulse_hold: got %h/%b want 00000012/0", rdata_out, rvalid); end
   endtask

   task test_accumulate();
      logic [RW-1:0] d; logic v;
      wr(1'b0, 10'd9, 32'd10);
      repeat (4) wr(1'b1, 10'd9, 32'd3);
      cyc();
      rd(10'd9, d, v);
      checks++; if (d !== 32'd22 || v !== 1'b1) begin errors++; $display("FAIL accumulate_b2b: got %0d/%b want 22/1", d, v); end
      checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL no_ovf_positive: got %b want 0", ovf_flag); end
      wr(1'b0, 10'd11, 32'hFFFF_FFFB);
      wr(1'b1, 10'd11, 32'd3);
      cyc();
      rd(10'd11, d, v);
      checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL accumulate_negative: got %h want fffffffe", d); end
      checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL no_ovf_mixed_sign: got %b want 0", ovf_flag); end
   endtask

   task test_read_first();
      logic [RW-1:0] d; logic v;
      wr(1'b0, 10'd7, 32'd1);
      cyc();
      wr_en = 1'b1; wr_acc = 1'b0; waddr_in = 10'd7; wdata_in = 32'd2;
      rd_en = 1'b1; raddr_in = 10'd7;
      @(negedge clk);
      wr_en = 1'b0;
      checks++; if (rdata_out !== 32'd1 || rvalid !== 1'b1) begin errors++; $display("FAIL same_cycle_rw: got %0d/%b want 1/1", rdata_out, rvalid); end
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (rdata_out !== 32'd1) begin errors++; $display("FAIL read_first_commit_edge: got %0d want 1", rdata_out); end
      rd(10'd7, d, v);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL read_after_commit: got %0d want 2", d); end
   endtask

   task test_overflow();
      logic [RW-1:0] d; logic v;
      wr(1'b0, 10'd100, 32'h7FFF_FFFF);
      wr(1'b1, 10'd100, 32'd1);
      checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_before_commit: got %b want 0", ovf_flag); end
      cyc();
      checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_flag); end
      rd(10'd100, d, v);
      checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL ovf_value: got %h want 80000000", d); end
      cyc(5);
      checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_flag); end
   endtask

   task test_clear();
      logic [RW-1:0] d; logic v;
      int n, bad;
      for (int i = 0; i < 8; i++) wr(1'b0, AB'(i), RW'(i + 1));
      for (int i = 1016; i < 1024; i++) wr(1'b0, AB'(i), 32'hA000_0000 + RW'(i));
      cyc();
      clr_start = 1'b1; wr_en = 1'b1; waddr_in = 10'd3; wdata_in = 32'h55; rd_en = 1'b1; raddr_in = 10'd1;
      @(negedge clk);
      clr_start = 1'b0; rd_en = 1'b0;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL clr_priority_rd: got rvalid %b want 0", rvalid); end
      checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", ovf_flag); end
      n = 0;
      while (ready === 1'b0 && n < 1000) begin
         wr_en = 1'b1; waddr_in = AB'(n); wdata_in = 32'hDEAD_0000 | RW'(n);
         clr_start = (n == 5);
         n++;
         @(negedge clk);
      end
      wr_en = 1'b0; clr_start = 1'b0;
      checks++; if (n !== 257) begin errors++; $display("FAIL clear_busy_cycles: got %0d want 257", n); end
      checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL clr_done_pulse: got %b want 1", clr_done); end
      cyc();
      checks++; if (clr_done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL clr_done_one_cycle: got %b/%b want 0/1", clr_done, ready); end
      bad = 0;
      for (int a = 0; a < 1024; a++) begin
         rd(AB'(a), d, v);
         if (d !== 32'h0 || v !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL clear_all_zero: got %0d nonzero entries want 0", bad); end
   endtask

   task test_reset_mid_clear();
      logic [RW-1:0] d; logic v;
      wr(1'b0, 10'd50, 32'hABCD);
      cyc();
      rd(10'd50, d, v);
      wr(1'b0, 10'd60, 32'h7FFF_FFFF);
      wr(1'b1, 10'd60, 32'd1);
      cyc();
      checks++; if (ovf_flag !== 1'b1 || rdata_out !== 32'hABCD) begin errors++; $display("FAIL pre_reset_state: got %b/%h want 1/0000abcd", ovf_flag, rdata_out); end
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      cyc(20);
      #2 rstn = 1'b0;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midclr_reset_ready: got %b want 1", ready); end
      checks++; if (ovf_flag !== 1'b0 || clr_done !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL midclr_reset_flags: got ovf %b done %b rvalid %b want 0 0 0", ovf_flag, clr_done, rvalid); end
      checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL midclr_reset_rdata: got %h want 0", rdata_out); end
      @(negedge clk); rstn = 1'b1;
      cyc();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", ready); end
      wr(1'b0, 10'd2, 32'h33);
      cyc();
      rd(10'd2, d, v);
      checks++; if (d !== 32'h33 || v !== 1'b1) begin errors++; $display("FAIL post_reset_rw: got %h/%b want 00000033/1", d, v); end
   endtask

   initial begin
      test_reset();
      test_overwrite();
      test_accumulate();
      test_read_first();
      test_overflow();
      test_clear();
      test_reset_mid_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
